// File: rtl/imem_loader_if.sv
// imem_loader_if: bundles the signals between the program source, the
// instruction RAM and the loader.
//   start, count         load request and word count (count clamps to 64)
//   in_data/valid/ready  byte stream handshake
//   we, waddr, wdata     instruction RAM write port
//   busy, cpu_hold, done load status
// Modport slave is the loader's view. Modport master is the driving
// environment's view.
interface imem_loader_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
);
    logic              start;
    logic [ADDR_W:0]   count;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [N-1:0]      wdata;
    logic              busy;
    logic              cpu_hold;
    logic              done;

    modport slave (
        input  start, count, in_data, in_valid,
        output in_ready, we, waddr, wdata, busy, cpu_hold, done
    );

    modport master (
        output start, count, in_data, in_valid,
        input  in_ready, we, waddr, wdata, busy, cpu_hold, done
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a program as a byte stream. It packs every 4 bytes
// little-endian into one 32-bit word and writes each word into the 64-entry
// instruction RAM. While the load runs it holds the CPU in reset. When the
// last word is written it pulses done for one cycle.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset
//   bus    imem_loader_if.slave (start/count, byte stream, RAM write, status)
// Every output is registered. cpu_hold is a copy of busy.
module imem_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(DEPTH);

    state_t          state;
    logic [ADDR_W:0] target;
    logic [ADDR_W:0] widx;      // one bit wider so it can equal a target of 64
    logic [1:0]      byte_cnt;
    logic [N-1:0]    word;
    logic [ADDR_W:0] req_words;

    assign req_words    = (bus.count > MAX_WORDS) ? MAX_WORDS : bus.count;
    assign bus.cpu_hold = bus.busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            target       <= '0;
            widx         <= '0;
            byte_cnt     <= '0;
            word         <= '0;
            bus.in_ready <= 1'b0;
            bus.we       <= 1'b0;
            bus.waddr    <= '0;
            bus.wdata    <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.we   <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        target   <= req_words;
                        byte_cnt <= '0;
                        widx     <= '0;
                        bus.busy <= 1'b1;
                        if (req_words == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state        <= RECV;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (bus.in_valid && bus.in_ready) begin
                        word[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // The fourth byte goes straight into wdata, so the
                            // write happens in the next cycle.
                            state        <= WRITE;
                            bus.in_ready <= 1'b0;
                            bus.we       <= 1'b1;
                            bus.waddr    <= widx[ADDR_W-1:0];
                            bus.wdata    <= {bus.in_data, word[23:0]};
                        end
                    end
                end
                WRITE: begin
                    widx <= widx + 1'b1;
                    if (widx + 1'b1 == target) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state        <= RECV;
                        byte_cnt     <= '0;
                        bus.in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: a directed testbench for imem_loader. A negedge monitor
// logs every RAM write, the done pulses and the busy and in_ready cycles.
// A single linear initial block drives the stimulus and checks the results
// against hand-computed values.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;

    imem_loader_if #(.N(32), .ADDR_W(6)) bus ();

    imem_loader #(.N(32), .ADDR_W(6), .DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor. It is the only writer of these logs.
    int          cyc = 0;
    int          wn = 0;
    logic [5:0]  wa [0:511];
    logic [31:0] wd [0:511];
    int          wcyc [0:511];
    int          done_n = 0, last_done = -1, busy_n = 0, rdy_n = 0, hold_bad = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.we) begin
            wa[wn]   <= bus.waddr;
            wd[wn]   <= bus.wdata;
            wcyc[wn] <= cyc;
            wn       <= wn + 1;
        end
        if (bus.done) begin
            done_n    <= done_n + 1;
            last_done <= cyc;
        end
        if (bus.busy)     busy_n   <= busy_n + 1;
        if (bus.in_ready) rdy_n    <= rdy_n + 1;
        if (bus.cpu_hold !== bus.busy) hold_bad <= hold_bad + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until the loader takes it. Before that,
    // in_valid stays low for 'gap' cycles, with start pulsed if poke is set.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        int n;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.start    = poke;
            bus.count    = 7'd5;
            @(posedge clk); #1;
            bus.start    = 1'b0;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("byte_accept_timeout", 64'(n >= 50), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Pulse start. Returns the index of the cycle in which start was sampled.
    task automatic do_start(input logic [6:0] cnt, output int s);
        bus.start = 1'b1;
        bus.count = cnt;
        @(negedge clk); #1;
        s = cyc - 1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle_timeout", 64'(n >= 2000), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int s, w0, d0, b0, r0;
        logic [7:0] bytes1 [0:3];
        logic [31:0] exp3 [0:2];
        bus.start = 1'b0; bus.count = '0; bus.in_data = '0; bus.in_valid = 1'b0;

        // Outputs while reset is held.
        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_hold",     64'(bus.cpu_hold), 64'd0);
        chk("rst_we_done",  64'({bus.we, bus.done}), 64'd0);
        chk("rst_waddr",    64'(bus.waddr),    64'd0);
        chk("rst_wdata",    64'(bus.wdata),    64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single word. Bytes 00,3D,00,91 with no gaps.
        bytes1[0] = 8'h00; bytes1[1] = 8'h3D; bytes1[2] = 8'h00; bytes1[3] = 8'h91;
        w0 = wn; d0 = done_n; b0 = busy_n;
        do_start(7'd1, s);
        for (int i = 0; i < 4; i++) send_byte(bytes1[i], 0, 1'b0);
        wait_idle();
        chk("w1_nwrites", 64'(wn - w0), 64'd1);
        chk("w1_waddr",   64'(wa[w0]),  64'd0);
        chk("w1_wdata",   64'(wd[w0]),  64'h91003D00);
        chk("w1_wcycle",  64'(wcyc[w0] - s), 64'd5);
        chk("w1_done_n",  64'(done_n - d0), 64'd1);
        chk("w1_done_cyc", 64'(last_done - s), 64'd6);
        // Busy runs from RECV through DONE: 4 + 1 + 1 cycles.
        chk("w1_busy_cycles", 64'(busy_n - b0), 64'd6);
        chk("w1_wdata_hold", 64'(bus.wdata), 64'h91003D00);

        // Count 0: no write, done comes right after start, in_ready never rises.
        w0 = wn; d0 = done_n; r0 = rdy_n;
        do_start(7'd0, s);
        wait_idle();
        chk("c0_nwrites", 64'(wn - w0), 64'd0);
        chk("c0_done_cyc", 64'(last_done - s), 64'd1);
        chk("c0_done_n", 64'(done_n - d0), 64'd1);
        chk("c0_ready", 64'(rdy_n - r0), 64'd0);

        // Full memory, and count 100 clamped to 64. Byte stream is 0..255.
        for (int pass = 0; pass < 2; pass++) begin
            w0 = wn; d0 = done_n;
            do_start(pass == 0 ? 7'd64 : 7'd100, s);
            for (int i = 0; i < 256; i++) send_byte(8'(i), 0, 1'b0);
            wait_idle();
            chk("full_nwrites", 64'(wn - w0), 64'd64);
            chk("full_done_cyc", 64'(last_done - s), 64'(5 * 64 + 1));
            chk("full_done_n", 64'(done_n - d0), 64'd1);
            chk("full_last_wdata", 64'(wd[w0 + 63]), 64'hFFFEFDFC);
            chk("full_w10", 64'(wd[w0 + 10]), 64'h2B2A2928);
            for (int k = 0; k < 64; k++)
                chk("full_waddr", 64'(wa[w0 + k]), 64'(k));
        end

        // Stalls on a 3-word load, with start poked while busy.
        exp3[0] = 32'hA3A2A1A0; exp3[1] = 32'hA7A6A5A4; exp3[2] = 32'hABAAA9A8;
        w0 = wn; d0 = done_n;
        do_start(7'd3, s);
        for (int i = 0; i < 12; i++)
            send_byte(8'hA0 + 8'(i), (i * 7) % 4, (i % 3) == 1);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("stall_nwrites", 64'(wn - w0), 64'd3);
        chk("stall_done_n", 64'(done_n - d0), 64'd1);
        chk("stall_idle_after", 64'(bus.busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_waddr", 64'(wa[w0 + k]), 64'(k));
            chk("stall_wdata", 64'(wd[w0 + k]), 64'(exp3[k]));
        end

        // Reset during a load: word 0 is written and word 1 has 2 bytes.
        w0 = wn;
        do_start(7'd4, s);
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), 0, 1'b0);
        chk("mid_busy_before", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'({bus.busy, bus.cpu_hold}), 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        chk("mid_rst_wdata", 64'(bus.wdata), 64'd0);
        chk("mid_rst_waddr", 64'(bus.waddr), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_nwrites_pre", 64'(wn - w0), 64'd1);
        do_start(7'd1, s);
        send_byte(8'h78, 0, 1'b0);
        send_byte(8'h56, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        wait_idle();
        chk("mid_nwrites", 64'(wn - w0), 64'd2);
        chk("mid_new_waddr", 64'(wa[w0 + 1]), 64'd0);
        chk("mid_new_wdata", 64'(wd[w0 + 1]), 64'h12345678);

        chk("cpu_hold_tracks_busy", 64'(hold_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
